breathing_counter: RTL and testbench

Parametrised successor to the plain up/down counter used for LED breathing. Produces a BITS-wide brightness ramp with a programmable step prescaler. Supports two modes: externally steered up/down with saturate or wrap, or an autonomous triangle with programmable dwell at both ends. Includes a built-in PWM stage, so it drives an LED pin directly and also exports the ramp value for other consumers.

---
 rtl/breathing_pkg.sv | 18 +
 rtl/tick_divider.sv | 30 +++
 rtl/breathing_counter.sv | 168 ++++++++++++++++
 tb/tb_breathing_counter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/breathing_pkg.sv
// Shared types and constants for the breathing LED ramp.
package breathing_pkg;

    // Ramp FSM states; UP is the reset state.
    typedef enum logic [1:0] {
        UP       = 2'd0,
        HOLD_TOP = 2'd1,
        DOWN     = 2'd2,
        HOLD_BOT = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic MODE_EXT = 1'b0;
    localparam logic MODE_TRI = 1'b1;

endpackage

// File: rtl/tick_divider.sv
// Step prescaler: emits a combinational tick every prescale+1 enabled clocks.
module tick_divider #(
    parameter int PRESCALE_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [PRESCALE_BITS-1:0] prescale,
    output logic                     tick
);

    localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);

    logic [PRESCALE_BITS-1:0] pre_cnt_reg;

    // >= rather than == so that lowering prescale mid-count ticks immediately.
    assign tick = en && (pre_cnt_reg >= prescale);

    // Count enabled clocks, restarting from zero on every tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_reg <= '0;
        end else if (tick) begin
            pre_cnt_reg <= '0;
        end else if (en) begin
            pre_cnt_reg <= pre_cnt_reg + PRE_ONE;
        end
    end

endmodule

// File: rtl/breathing_counter.sv
// Brightness ramp (external up/down or auto triangle with dwell) plus PWM output.
module breathing_counter
    import breathing_pkg::*;
#(
    parameter int BITS          = 8,
    parameter int PRESCALE_BITS = 16,
    parameter int HOLD_BITS     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic                     dir,
    input  logic                     wrap,
    input  logic [PRESCALE_BITS-1:0] prescale,
    input  logic [HOLD_BITS-1:0]     hold_steps,
    output logic [BITS-1:0]          out,
    output logic                     out_dir,
    output logic                     step,
    output logic                     pwm
);

    localparam logic [BITS-1:0]      MAX      = {BITS{1'b1}};
    localparam logic [BITS-1:0]      ZERO     = {BITS{1'b0}};
    localparam logic [BITS-1:0]      ONE      = BITS'(1);
    localparam logic [BITS-1:0]      MAX_M1   = MAX - ONE;
    localparam logic [HOLD_BITS-1:0] HOLD_ONE = HOLD_BITS'(1);

    logic tick;

    state_t                state_reg, state_next;
    logic [BITS-1:0]       out_reg, out_next;
    logic                  out_dir_reg, out_dir_next;
    logic                  step_reg, step_next;
    logic [HOLD_BITS-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [BITS-1:0]       pwm_cnt_reg;
    logic                  pwm_reg;

    tick_divider #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_tick_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    // Ramp state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= UP;
            out_reg      <= '0;
            out_dir_reg  <= DIR_UP;
            step_reg     <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            out_reg      <= out_next;
            out_dir_reg  <= out_dir_next;
            step_reg     <= step_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Next-state logic for both ramp modes; everything holds while en is low.
    always_comb begin
        state_next    = state_reg;
        out_next      = out_reg;
        out_dir_next  = out_dir_reg;
        step_next     = 1'b0;
        hold_cnt_next = hold_cnt_reg;

        if (mode == MODE_EXT) begin
            // Track dir continuously so a switch to triangle mode resumes in
            // the last selected direction with no stale hold count.
            if (en) begin
                state_next    = (dir == DIR_DOWN) ? DOWN : UP;
                out_dir_next  = dir;
                hold_cnt_next = '0;
            end
            if (tick) begin
                step_next = 1'b1;
                if (dir == DIR_UP) begin
                    if (out_reg == MAX) begin
                        out_next = wrap ? ZERO : MAX;
                    end else begin
                        out_next = out_reg + ONE;
                    end
                end else begin
                    if (out_reg == ZERO) begin
                        out_next = wrap ? MAX : ZERO;
                    end else begin
                        out_next = out_reg - ONE;
                    end
                end
            end
        end else if (tick) begin
            step_next = 1'b1;
            case (state_reg)
                UP: begin
                    if (out_reg != MAX) begin
                        out_next = out_reg + ONE;
                    end else if (hold_steps == '0) begin
                        state_next = DOWN;
                        out_next   = MAX_M1;
                    end else begin
                        state_next    = HOLD_TOP;
                        hold_cnt_next = HOLD_ONE;
                    end
                end
                HOLD_TOP: begin
                    if (hold_cnt_reg >= hold_steps) begin
                        state_next = DOWN;
                        out_next   = MAX_M1;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + HOLD_ONE;
                    end
                end
                DOWN: begin
                    if (out_reg != ZERO) begin
                        out_next = out_reg - ONE;
                    end else if (hold_steps == '0) begin
                        state_next = UP;
                        out_next   = ONE;
                    end else begin
                        state_next    = HOLD_BOT;
                        hold_cnt_next = HOLD_ONE;
                    end
                end
                default: begin
                    if (hold_cnt_reg >= hold_steps) begin
                        state_next = UP;
                        out_next   = ONE;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + HOLD_ONE;
                    end
                end
            endcase

            // out_dir announces the next change, so it turns as soon as the
            // value reaches an end of the ramp, not one tick later.
            case (state_next)
                UP:       out_dir_next = (out_next == MAX) ? DIR_DOWN : DIR_UP;
                HOLD_TOP: out_dir_next = DIR_DOWN;
                DOWN:     out_dir_next = (out_next == ZERO) ? DIR_UP : DIR_DOWN;
                default:  out_dir_next = DIR_UP;
            endcase
        end
    end

    // Free-running PWM compare; runs regardless of en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_reg <= '0;
            pwm_reg     <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + ONE;
            pwm_reg     <= (pwm_cnt_reg < out_reg);
        end
    end

    assign out     = out_reg;
    assign out_dir = out_dir_reg;
    assign step    = step_reg;
    assign pwm     = pwm_reg;

endmodule

// File: tb/tb_breathing_counter.sv
// Directed bench for breathing_counter at BITS=4.
module tb_breathing_counter;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        mode;
    logic        dir;
    logic        wrap;
    logic [15:0] prescale;
    logic [7:0]  hold_steps;
    logic [3:0]  out;
    logic        out_dir;
    logic        step;
    logic        pwm;

    int n_checks = 0;
    int n_fail   = 0;

    breathing_counter #(
        .BITS(4),
        .PRESCALE_BITS(16),
        .HOLD_BITS(8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode),
        .dir        (dir),
        .wrap       (wrap),
        .prescale   (prescale),
        .hold_steps (hold_steps),
        .out        (out),
        .out_dir    (out_dir),
        .step       (step),
        .pwm        (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across two edges, then release just after an edge.
    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_out;
        int exp_dir;
        int q;
        int hi;

        reset_n    = 1'b0;
        en         = 1'b0;
        mode       = 1'b0;
        dir        = 1'b0;
        wrap       = 1'b0;
        prescale   = 16'd0;
        hold_steps = 8'd0;

        // Reset values, and PWM stays low with out=0.
        do_reset();
        check("rst_out", out, 0);
        check("rst_out_dir", out_dir, 0);
        check("rst_step", step, 0);
        check("rst_pwm", pwm, 0);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            hi += pwm;
        end
        check("pwm_zero_high_count", hi, 0);

        // Triangle without dwell: period 30.
        mode = 1'b1; en = 1'b1; prescale = 16'd0; hold_steps = 8'd0;
        do_reset();
        for (int k = 1; k <= 62; k++) begin
            cyc();
            q = k % 30;
            exp_out = (q <= 15) ? q : 30 - q;
            exp_dir = (q >= 15) ? 1 : 0;
            check($sformatf("tri_out k=%0d", k), out, exp_out);
            check($sformatf("tri_dir k=%0d", k), out_dir, exp_dir);
            check($sformatf("tri_step k=%0d", k), step, 1);
        end

        // Triangle with dwell 2: 15 and 0 each last 3 ticks, period 34.
        hold_steps = 8'd2;
        do_reset();
        for (int k = 1; k <= 72; k++) begin
            cyc();
            q = (k - 1) % 34;
            if (q <= 14)      exp_out = q + 1;
            else if (q <= 16) exp_out = 15;
            else if (q <= 31) exp_out = 31 - q;
            else              exp_out = 0;
            check($sformatf("dwell_out k=%0d", k), out, exp_out);
        end

        // External mode: saturate up, ramp down, saturate down, then wrap.
        mode = 1'b0; dir = 1'b0; wrap = 1'b0; hold_steps = 8'd0;
        do_reset();
        for (int k = 1; k <= 20; k++) cyc();
        check("ext_sat_top", out, 15);
        check("ext_sat_dir", out_dir, 0);
        dir = 1'b1;
        cyc();
        check("ext_down1", out, 14);
        check("ext_down_dir", out_dir, 1);
        cyc();
        check("ext_down2", out, 13);
        for (int k = 0; k < 14; k++) cyc();
        check("ext_sat_bot", out, 0);
        wrap = 1'b1;
        cyc();
        check("ext_wrap_to_max", out, 15);
        dir = 1'b0;
        cyc();
        check("ext_wrap_to_zero", out, 0);

        // Prescaler 3: step every 4 enabled clocks; freeze; resume.
        dir = 1'b0; wrap = 1'b0; prescale = 16'd3;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check($sformatf("pre_step k=%0d", k), step, (k % 4 == 0) ? 1 : 0);
        end
        check("pre_out_after12", out, 3);
        cyc();
        check("pre_step_k13", step, 0);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("frz_out", out, 3);
            check("frz_step", step, 0);
        end
        en = 1'b1;
        cyc();
        check("resume_step1", step, 0);
        cyc();
        check("resume_step2", step, 0);
        cyc();
        check("resume_step3", step, 1);
        check("resume_out", out, 4);

        // PWM duty with out frozen at 4.
        prescale = 16'd0; dir = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) cyc();
        en = 1'b0;
        check("pwm_set_out", out, 4);
        cyc();
        cyc();
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            hi += pwm;
        end
        check("pwm_duty4_high_count", hi, 4);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            hi += pwm;
        end
        check("pwm_duty4_second_period", hi, 4);

        // Asynchronous reset in HOLD_TOP, then restart from 0 going up.
        en = 1'b1; mode = 1'b1; hold_steps = 8'd5; prescale = 16'd0;
        do_reset();
        for (int k = 0; k < 17; k++) cyc();
        check("hold_top_out", out, 15);
        check("hold_top_dir", out_dir, 1);
        reset_n = 1'b0;
        #2;
        check("async_rst_out", out, 0);
        check("async_rst_dir", out_dir, 0);
        check("async_rst_step", step, 0);
        cyc();
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check($sformatf("restart_out k=%0d", k), out, k);
            check($sformatf("restart_dir k=%0d", k), out_dir, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
